// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data response, aligns and extends load data, drops orphaned responses.
// Optional define MS_FWD_EN adds the ms_to_ds_fwd_bus forwarding port toward decode.
module mem_stage #(
    parameter int unsigned ES_TO_MS_WD = 160,
    parameter int unsigned MS_TO_WS_WD = 155
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   es_to_ms_valid,
    input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
    output logic                   ms_allowin,
    input  logic                   ws_allowin,
    output logic                   ms_to_ws_valid,
    output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
    input  logic                   handle_ex,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    output logic                   ms_valid,
    output logic                   ms_ex_or_eret
`ifdef MS_FWD_EN
    ,
    output logic [38:0]            ms_to_ds_fwd_bus
`endif
);

    logic [ES_TO_MS_WD-1:0] bus_r;
    logic                   buf_valid;
    logic [31:0]            buf_data;
    logic [1:0]             discard_cnt;

    logic        mem_wait;
    logic        res_from_mem;
    logic [2:0]  load_op;
    logic [31:0] alu_result;

    assign mem_wait     = bus_r[159];
    assign res_from_mem = bus_r[158];
    assign load_op      = bus_r[157:155];
    assign alu_result   = bus_r[63:32];

    logic rsp_own;
    logic ms_ready_go;
    logic capture;
    logic mem_pending;
    logic transfer_in;

    // A response belongs to the MEM instruction only when no orphans are queued ahead of it
    assign rsp_own     = data_sram_data_ok && (discard_cnt == 2'd0);
    assign ms_ready_go = !mem_wait || buf_valid || rsp_own;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign capture     = rsp_own && ms_valid && mem_wait && !buf_valid;
    assign mem_pending = ms_valid && mem_wait && !buf_valid && !rsp_own;
    assign transfer_in = es_to_ms_valid && ms_allowin && !handle_ex;

    assign ms_ex_or_eret = ms_valid && (bus_r[154] || bus_r[115]);

    logic [2:0] cnt_sum;
    logic [1:0] cnt_next;

    // Drop first, then count requests orphaned by a flush; saturate at two
    always_comb begin
        cnt_sum = 3'(discard_cnt);
        if (data_sram_data_ok && (discard_cnt != 2'd0)) begin
            cnt_sum = cnt_sum - 3'd1;
        end
        if (handle_ex && mem_pending) begin
            cnt_sum = cnt_sum + 3'd1;
        end
        if (handle_ex && es_to_ms_valid && es_to_ms_bus[159]) begin
            cnt_sum = cnt_sum + 3'd1;
        end
        cnt_next = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];
    end

    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    // Load alignment and extension
    always_comb begin
        rd_word = buf_valid ? buf_data : data_sram_rdata;
        case (alu_result[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = alu_result[1] ? rd_word[31:16] : rd_word[15:0];
        case (load_op)
            3'd1:    load_data = {{24{rd_byte[7]}}, rd_byte};
            3'd2:    load_data = {24'b0, rd_byte};
            3'd3:    load_data = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_data = {16'b0, rd_half};
            default: load_data = rd_word;
        endcase
        final_result = res_from_mem ? load_data : alu_result;
    end

    assign ms_to_ws_bus = {bus_r[154:64], final_result, bus_r[31:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            buf_valid   <= 1'b0;
            discard_cnt <= 2'd0;
        end else begin
            discard_cnt <= cnt_next;
            if (handle_ex) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (transfer_in) begin
                buf_valid <= 1'b0;
            end else if (capture) begin
                buf_valid <= 1'b1;
            end
        end
    end

    // Payload registers carry no reset; ms_valid and buf_valid qualify them
    always_ff @(posedge clk) begin
        if (transfer_in) begin
            bus_r <= es_to_ms_bus;
        end
        if (capture) begin
            buf_data <= data_sram_rdata;
        end
    end

`ifdef MS_FWD_EN
    logic fwd_valid;
    logic fwd_block;

    assign fwd_valid = ms_valid && (bus_r[72:69] != 4'd0) && !bus_r[154];
    assign fwd_block = fwd_valid && (bus_r[73] || (res_from_mem && !ms_ready_go));
    assign ms_to_ds_fwd_bus = {fwd_valid, fwd_block, bus_r[68:64], final_result};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model (request/owner queue) plus directed vectors with literal results.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         es_to_ms_valid = 1'b0;
    logic [159:0] es_to_ms_bus = '0;
    logic         ms_allowin;
    logic         ws_allowin = 1'b1;
    logic         ms_to_ws_valid;
    logic [154:0] ms_to_ws_bus;
    logic         handle_ex = 1'b0;
    logic         data_sram_data_ok = 1'b0;
    logic [31:0]  data_sram_rdata = '0;
    logic         ms_valid;
    logic         ms_ex_or_eret;
`ifdef MS_FWD_EN
    logic [38:0]  ms_to_ds_fwd_bus;
`endif

    int total = 0;
    int bad = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .handle_ex         (handle_ex),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_valid          (ms_valid),
        .ms_ex_or_eret     (ms_ex_or_eret)
`ifdef MS_FWD_EN
        ,
        .ms_to_ds_fwd_bus  (ms_to_ds_fwd_bus)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [154:0] act, input logic [154:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, 155'(act), 155'(exp));
    endtask

    function automatic logic [159:0] mk(input logic mw, input logic rfm, input logic [2:0] op,
                                        input logic ex, input logic eret,
                                        input logic [31:0] alu, input logic [31:0] pc);
        logic [159:0] b;
        b = '0;
        b[159]     = mw;
        b[158]     = rfm;
        b[157:155] = op;
        b[154]     = ex;
        b[153:149] = ex ? 5'h0c : 5'h00;
        b[147:116] = ex ? alu : 32'h0;
        b[115]     = eret;
        b[105:74]  = pc ^ 32'h5a5a_0000;
        b[72:69]   = (ex || eret || (mw && !rfm)) ? 4'h0 : 4'hf;
        b[68:64]   = pc[6:2];
        b[63:32]   = alu;
        b[31:0]    = pc;
        return b;
    endfunction

    // Architectural load result computed from the address and the returned word
    function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = rd >> {addr[1:0], 3'b000};
        b  = sh[7:0];
        h  = addr[1] ? rd[31:16] : rd[15:0];
        case (op)
            3'd1:    return (b >= 8'd128) ? (32'hFFFF_FF00 | {24'b0, b}) : {24'b0, b};
            3'd2:    return {24'b0, b};
            3'd3:    return (h >= 16'd32768) ? (32'hFFFF_0000 | {16'b0, h}) : {16'b0, h};
            3'd4:    return {16'b0, h};
            default: return rd;
        endcase
    endfunction

    // Model: MEM occupant plus a queue of outstanding requests tagged by owner pc (DEAD once flushed)
    localparam logic [31:0] DEAD = 32'hFFFF_FFFF;
    initial begin
        logic [31:0]  req_q[$];
        logic         occ, occ_has, ready, exp_allowin;
        logic [159:0] occ_bus;
        logic [31:0]  occ_rd, last_req_pc, tag, fr;
        logic [154:0] exp_bus;
        occ = 1'b0; occ_has = 1'b0; occ_bus = '0; occ_rd = '0; last_req_pc = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                occ = 1'b0;
                req_q.delete();
                last_req_pc = '0;
            end else begin
                if (es_to_ms_valid && es_to_ms_bus[159] && (es_to_ms_bus[31:0] != last_req_pc)) begin
                    req_q.push_back(es_to_ms_bus[31:0]);
                    last_req_pc = es_to_ms_bus[31:0];
                end
                if (data_sram_data_ok) begin
                    if (req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL model_rsp: response with no request at %0t", $time);
                    end else begin
                        tag = req_q.pop_front();
                        if (occ && occ_bus[159] && !occ_has && (tag == occ_bus[31:0])) begin
                            occ_has = 1'b1;
                            occ_rd  = data_sram_rdata;
                        end
                    end
                end
                ready       = occ && (!occ_bus[159] || occ_has);
                exp_allowin = !occ || (ready && ws_allowin);
                chk("ms_valid", 155'(ms_valid), 155'(occ));
                chk("ms_to_ws_valid", 155'(ms_to_ws_valid), 155'(ready));
                chk("ms_allowin", 155'(ms_allowin), 155'(exp_allowin));
                chk("ms_ex_or_eret", 155'(ms_ex_or_eret), 155'(occ && (occ_bus[154] || occ_bus[115])));
                if (ready) begin
                    fr = occ_bus[158] ? load_val(occ_bus[157:155], occ_bus[63:32], occ_rd) : occ_bus[63:32];
                    exp_bus = {occ_bus[154:64], fr, occ_bus[31:0]};
                    chk("ms_to_ws_bus", ms_to_ws_bus, exp_bus);
                end
`ifdef MS_FWD_EN
                begin
                    logic fv;
                    fv = occ && (occ_bus[72:69] != 4'd0) && !occ_bus[154];
                    chk("fwd_flags", 155'(ms_to_ds_fwd_bus[38:37]),
                        155'({fv, fv && (occ_bus[73] || (occ_bus[158] && !ready))}));
                end
`endif
                if (handle_ex) begin
                    occ = 1'b0;
                    foreach (req_q[i]) req_q[i] = DEAD;
                end else begin
                    if (ready && ws_allowin) occ = 1'b0;
                    if (es_to_ms_valid && exp_allowin) begin
                        occ     = 1'b1;
                        occ_bus = es_to_ms_bus;
                        occ_has = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step(input logic ev, input logic [159:0] eb, input logic wa,
                        input logic hx, input logic dk, input logic [31:0] rd);
        @(posedge clk);
        #1;
        es_to_ms_valid    = ev;
        es_to_ms_bus      = eb;
        ws_allowin        = wa;
        handle_ex         = hx;
        data_sram_data_ok = dk;
        data_sram_rdata   = rd;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic load_test(input string nm, input logic [2:0] op, input logic [31:0] alu,
                             input logic [31:0] rdat, input logic [31:0] exp, input logic [31:0] pc);
        step(1'b1, mk(1'b1, 1'b1, op, 1'b0, 1'b0, alu, pc), 1'b1, 1'b0, 1'b0, 32'h0);
        idle();
        #1 chk32({nm, "_wait"}, 32'(ms_to_ws_valid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, rdat);
        #1 chk32({nm, "_valid"}, 32'(ms_to_ws_valid), 32'd1);
        chk32(nm, ms_to_ws_bus[63:32], exp);
    endtask

    initial begin
        logic [159:0] a_instr, st;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk32("rst_ms_valid", 32'(ms_valid), 32'd0);
        chk32("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
        chk32("rst_allowin", 32'(ms_allowin), 32'd1);
        chk32("rst_ex_or_eret", 32'(ms_ex_or_eret), 32'd0);

        load_test("lb",  3'd1, 32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_FFFF, 32'h0000_0100);
        load_test("lbu", 3'd2, 32'h0000_1002, 32'h80FF_7F01, 32'h0000_00FF, 32'h0000_0104);
        load_test("lh",  3'd3, 32'h0000_2002, 32'h8001_1234, 32'hFFFF_8001, 32'h0000_0108);
        load_test("lhu", 3'd4, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001, 32'h0000_010c);
        load_test("lw",  3'd0, 32'h0000_2000, 32'h8001_1234, 32'h8001_1234, 32'h0000_0110);
        load_test("lb0", 3'd1, 32'h0000_3001, 32'h0000_7F00, 32'h0000_007F, 32'h0000_0114);
        load_test("op7", 3'd7, 32'h0000_3003, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0000_0118);
        idle();

        // Response arrives while WB is stalled; result must be held and emitted once
        a_instr = mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_0077, 32'h0000_0204);
        step(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_0200), 1'b1, 1'b0, 1'b0, 32'h0);
        idle();
        step(1'b1, a_instr, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        #1 chk32("stall_allowin", 32'(ms_allowin), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, a_instr, 1'b0, 1'b0, 1'b0, 32'h1111_1111);
            #1 chk32("stall_hold", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
        end
        step(1'b1, a_instr, 1'b1, 1'b0, 1'b0, 32'h2222_2222);
        #1 chk32("stall_release", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
        idle();
        #1 chk32("stall_next", ms_to_ws_bus[63:32], 32'h0000_0077);
        idle();

        // Flush with a waiting load in MEM and a store in EX: two responses become orphans
        st = mk(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_4000, 32'h0000_0304);
        step(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0300), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, st, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, st, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_5000, 32'h0000_0380), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hAAAA_AAAA);
        #1 chk32("drop1", 32'(ms_to_ws_valid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hBBBB_BBBB);
        #1 chk32("drop2", 32'(ms_to_ws_valid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
        #1 chk32("third_rsp", ms_to_ws_bus[63:32], 32'h1234_5678);
        chk32("third_valid", 32'(ms_to_ws_valid), 32'd1);
        idle();

        // Flush in the same cycle the MEM load is answered, nothing pending in EX
        step(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_6000, 32'h0000_0400), 1'b1, 1'b0, 1'b0, 32'h0);
        idle();
        step(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h0F0F_0F0F);
        step(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_6004, 32'h0000_0404), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D);
        #1 chk32("same_cyc_no_ex", ms_to_ws_bus[63:32], 32'h0BAD_F00D);
        idle();

        // Same-cycle answer plus a store pending in EX: exactly one orphan
        st = mk(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_7000, 32'h0000_0504);
        step(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_7004, 32'h0000_0500), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, st, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, st, 1'b1, 1'b1, 1'b1, 32'h3333_3333);
        step(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_7008, 32'h0000_0580), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h5555_5555);
        #1 chk32("same_cyc_drop", 32'(ms_to_ws_valid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h6666_6666);
        #1 chk32("same_cyc_ex", ms_to_ws_bus[63:32], 32'h6666_6666);
        idle();

        // Back-to-back ALU ops, third raises an exception, fourth is eret
        for (int k = 0; k < 4; k++) begin
            step(1'b1, mk(1'b0, 1'b0, 3'd0, (k == 2), (k == 3), 32'h0000_1000 + 32'(k), 32'h0000_0600 + 32'(4 * k)),
                 1'b1, 1'b0, 1'b0, 32'h0);
            if (k > 0) begin
                #1 chk32("alu_res", ms_to_ws_bus[63:32], 32'h0000_1000 + 32'(k - 1));
                chk32("alu_valid", 32'(ms_to_ws_valid), 32'd1);
                chk32("alu_ex_or_eret", 32'(ms_ex_or_eret), 32'((k - 1) >= 2));
            end
        end
        idle();
        #1 chk32("eret_flag", 32'(ms_ex_or_eret), 32'd1);
        chk32("alu_last", ms_to_ws_bus[63:32], 32'h0000_1003);

        // Reset while a load waits
        step(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_8000, 32'h0000_0700), 1'b1, 1'b0, 1'b0, 32'h0);
        idle();
        #1 chk32("wait_ms_valid", 32'(ms_valid), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk32("rst2_ms_valid", 32'(ms_valid), 32'd0);
        chk32("rst2_allowin", 32'(ms_allowin), 32'd1);
        chk32("rst2_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);

        // After reset the discard count is clear: a new load takes the next response
        step(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_9000, 32'h0000_0800), 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h7777_8888);
        #1 chk32("post_rst_load", ms_to_ws_bus[63:32], 32'h7777_8888);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM pipeline stage that transmits to the writeback stage. It accepts the execute-stage bus and waits for the SRAM-like data_ok response of any load or store already issued in EX. It then aligns and extends load data and sends the fixed ms_to_ws bus (`MS_TO_WS_BUS_WD`, 155 bits) downstream. It also discards responses that are orphaned when WB flushes the pipeline on an exception or eret.

Parameters:
ES_TO_MS_WD, 160, width of es_to_ms_bus
MS_TO_WS_WD, 155, width of ms_to_ws_bus (equals `MS_TO_WS_BUS_WD`)

Ports:
clk  in  1  clock; single clock domain
reset  in  1  synchronous, active-high reset
es_to_ms_valid  in  1  EX holds a valid instruction
es_to_ms_bus  in  160  mem_wait[159], res_from_mem[158], load_op[157:155], then the ms_to_ws field layout in [154:0] with alu_result in [63:32]
ms_allowin  out  1  MEM can accept from EX this cycle
ws_allowin  in  1  WB can accept
ms_to_ws_valid  out  1  valid toward WB
ms_to_ws_bus  out  155  ex[154], exccode[153:149], bd[148], badvaddr[147:116], eret[115], mtc0[114], cp0_addr[113:106], cp0_wdata[105:74], res_from_cp0[73], rf_we[72:69], dest[68:64], final_result[63:32], pc[31:0]
handle_ex  in  1  WB flush (exception or eret)
data_sram_data_ok  in  1  one data response returned
data_sram_rdata  in  32  response data
ms_valid  out  1  MEM occupied (used by EX to block stores after an ex/eret)
ms_ex_or_eret  out  1  ms_valid && (ex || eret)
ms_to_ds_fwd_bus  out  39  present only with MS_FWD_EN

Behaviour:
- Reset values: ms_valid=0, buf_valid=0, discard_cnt=0, ms_to_ws_valid=0, ms_ex_or_eret=0. The bus register is not reset.
- Transfer in: when es_to_ms_valid && ms_allowin, latch the bus and clear buf_valid.
- Readiness:
  - ms_ready_go = !mem_wait || buf_valid || (data_ok && discard_cnt==0).
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Capture: if data_ok arrives with discard_cnt==0 and MEM is waiting, rdata goes into buf with buf_valid=1. The same cycle may forward directly; this gives zero added latency when ws_allowin=1.
- At most one outstanding response per instruction; responses return in order.
- Discard counter (2 bits, saturates at 2, must never wrap):
  - On handle_ex, add 1 if MEM is valid, mem_wait=1, not yet answered, and the current data_ok is not answering it.
  - Also add 1 if es_to_ms_valid with es mem_wait=1.
  - Any data_ok while discard_cnt>0 decrements it and is dropped; it never fills buf.
  - data_ok in the same cycle as handle_ex is applied first (decrement or belongs to the flushed MEM instruction), then increments are added.
- Flush: handle_ex sets ms_valid<=0 and blocks the same-cycle EX transfer (ms_valid stays 0). It has priority over transfer-in.
- Load data, with a = alu_result[1:0] and rd = buf_valid ? buf : rdata:
  - load_op 0 = LW: rd.
  - 1 = LB: sign-extend rd byte a.
  - 2 = LBU: zero-extend rd byte a.
  - 3 = LH: sign-extend rd half a[1].
  - 4 = LHU: zero-extend rd half a[1].
  - 5-7: treated as LW.
- final_result = res_from_mem ? load data : alu_result. All other fields pass through unchanged.
- Exceptions: if ex=1, EX issued no request (mem_wait is 0 by contract). MEM forwards as ready, and WB suppresses rf_we.
- States (derived): EMPTY (ms_valid=0); WAIT (valid, mem_wait, no data); READY (valid, ready_go); STALL (READY && !ws_allowin, held with bus and buf stable).

Optional Feature:
MS_FWD_EN:
- Defined: ms_to_ds_fwd_bus = {fwd_valid, fwd_block, dest, final_result}.
  - fwd_valid = ms_valid && rf_we!=0 && !ex.
  - fwd_block = fwd_valid && (res_from_cp0 || (res_from_mem && !ms_ready_go)).
- Undefined: the port and its logic are absent. Decode stalls on any MEM-stage hazard.

Test Plan:
- LB, alu_result=0x1002, rdata=0x80FF7F01, data_ok 2 cycles after entry -> ms_to_ws_valid rises the data_ok cycle, final_result=0xFFFFFFFF; LBU gives 0x000000FF.
- LH at addr 0x...2, rdata=0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001; LW -> 0x80011234.
- data_ok with ws_allowin=0 for 3 cycles -> buf holds rdata; bus stable; no second capture; on release, result emitted once.
- Load waiting in MEM plus store issued in EX, handle_ex pulsed -> discard_cnt=2; next two data_ok dropped; a new load entering afterward receives the third data_ok.
- handle_ex same cycle as data_ok for the MEM load -> discard_cnt stays 0 (0 added for MEM, plus 1 if EX has a request pending).
- ALU op (mem_wait=0), ws_allowin=1 back-to-back -> one instruction per cycle, final_result=alu_result; reset mid-WAIT -> all state cleared next cycle.
